// File: rtl/segment_pkg.sv
// rtl/segment_pkg.sv - shared widths and FSM state type for the segment read server
package segment_pkg;
  localparam int SEG_IW = 8;
  localparam int SEG_DW = 64;
  localparam int SEG_AW = 32;

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } state_t;
endpackage

// File: rtl/segment_r_outfifo.sv
// rtl/segment_r_outfifo.sv - 2-entry output FIFO carrying {end, data} tokens
module segment_r_outfifo #(
  parameter int W = 65
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_d,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] ent [2];
  logic         rptr;
  logic         wptr;

  always_ff @(posedge clock) begin
    if (push) ent[wptr] <= push_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = ent[rptr];
endmodule

// File: rtl/segment_r_responder.sv
// rtl/segment_r_responder.sv - loadable read-only table answering addr/data token streams
module segment_r_responder
  import segment_pkg::*;
#(
  parameter int IW    = SEG_IW,
  parameter int DEPTH = 2 ** IW,
  parameter int DW    = SEG_DW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DW-1:0]     load_d,
  input  logic              load_e,
  input  logic              load_v,
  output logic              load_b,
  input  logic [SEG_AW-1:0] segment_r_addr_d,
  input  logic              segment_r_addr_e,
  input  logic              segment_r_addr_v,
  output logic              segment_r_addr_b,
  output logic [DW-1:0]     segment_r_data_d,
  output logic              segment_r_data_e,
  output logic              segment_r_data_v,
  input  logic              segment_r_data_b,
  output logic              err
);
  state_t        state;
  logic [IW-1:0] wptr;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  logic          rd_e;
  logic          rd_zero;
  logic          inflight;
  logic [1:0]    count;
  logic [DW:0]   head;
  logic [DW:0]   rd_tok;
  logic          load_fire;
  logic          addr_fire;
  logic          addr_hi_bad;
  logic          bypass;
  logic          fifo_push;
  logic          fifo_pop;

  assign load_fire   = load_v && !load_b;
  assign addr_fire   = segment_r_addr_v && !segment_r_addr_b;
  assign addr_hi_bad = |segment_r_addr_d[SEG_AW-1:IW];

  assign load_b           = (state == SERVE);
  assign segment_r_addr_b = (state != SERVE) ||
                            (({1'b0, count} + {2'b00, inflight}) >= 3'd2);

  always_ff @(posedge clock) begin
    if (load_fire && !load_e) mem[wptr] <= load_d;
    rd_q <= mem[segment_r_addr_d[IW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= LOAD;
      wptr     <= '0;
      err      <= 1'b0;
      inflight <= 1'b0;
      rd_e     <= 1'b0;
      rd_zero  <= 1'b0;
    end else begin
      inflight <= addr_fire;
      if (addr_fire) begin
        rd_e    <= segment_r_addr_e;
        rd_zero <= segment_r_addr_e || addr_hi_bad;
        if (!segment_r_addr_e && addr_hi_bad) err <= 1'b1;
      end
      case (state)
        LOAD: begin
          if (load_fire) begin
            if (load_e) begin
              state <= SERVE;
            end else begin
              wptr <= wptr + 1'b1;
              if (wptr == IW'(DEPTH - 1)) err <= 1'b1;
            end
          end
        end
        SERVE: state <= SERVE;
        default: state <= LOAD;
      endcase
    end
  end

  // With the FIFO empty the in-flight read is presented directly, giving one-cycle latency.
  assign rd_tok    = {rd_e, rd_zero ? {DW{1'b0}} : rd_q};
  assign bypass    = (count == 2'd0) && inflight;
  assign fifo_push = inflight && !(bypass && !segment_r_data_b);
  assign fifo_pop  = (count != 2'd0) && !segment_r_data_b;

  segment_r_outfifo #(.W(DW + 1)) u_outfifo (
    .clock  (clock),
    .reset  (reset),
    .push   (fifo_push),
    .push_d (rd_tok),
    .pop    (fifo_pop),
    .head   (head),
    .count  (count)
  );

  always_comb begin
    segment_r_data_v = (count != 2'd0) || inflight;
    segment_r_data_e = 1'b0;
    segment_r_data_d = '0;
    if (count != 2'd0) begin
      segment_r_data_e = head[DW];
      segment_r_data_d = head[DW-1:0];
    end else if (inflight) begin
      segment_r_data_e = rd_tok[DW];
      segment_r_data_d = rd_tok[DW-1:0];
    end
  end
endmodule

// File: tb/tb_segment_r_responder.sv
// tb/tb_segment_r_responder.sv - scoreboard bench for segment_r_responder
module tb_segment_r_responder;
  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] load_d;
  logic        load_e;
  logic        load_v;
  logic        load_b;
  logic [31:0] addr_d;
  logic        addr_e;
  logic        addr_v;
  logic        addr_b;
  logic [63:0] data_d;
  logic        data_e;
  logic        data_v;
  logic        data_b;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cycle = 0;
  int first_acc = 0;
  logic [64:0] sb[$];
  int pop_cycles[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  segment_r_responder dut (
    .clock            (clock),
    .reset            (reset),
    .load_d           (load_d),
    .load_e           (load_e),
    .load_v           (load_v),
    .load_b           (load_b),
    .segment_r_addr_d (addr_d),
    .segment_r_addr_e (addr_e),
    .segment_r_addr_v (addr_v),
    .segment_r_addr_b (addr_b),
    .segment_r_data_d (data_d),
    .segment_r_data_e (data_e),
    .segment_r_data_v (data_v),
    .segment_r_data_b (data_b),
    .err              (err)
  );

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (data_v && !data_b) begin
      pop_cycles.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_token", {data_e, data_d}, 65'h1_dead_dead_dead_dead);
      end else begin
        check("data_token", {data_e, data_d}, sb.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    addr_v = 1'b0;
    load_v = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [63:0] d, input logic e);
    int n = 0;
    load_d = d;
    load_e = e;
    load_v = 1'b1;
    @(negedge clock);
    check("addr_b_in_load", addr_b, 1);
    while (load_b && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("load_accept", load_b, 0);
    @(posedge clock);
    #1;
    load_v = 1'b0;
    load_e = 1'b0;
  endtask

  task automatic send_addr(input logic [31:0] a, input logic e, input logic [63:0] exp);
    int n = 0;
    addr_d = a;
    addr_e = e;
    addr_v = 1'b1;
    @(negedge clock);
    while (addr_b && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (addr_b) begin
      check("addr_accept_timeout", addr_b, 0);
    end else begin
      sb.push_back({e, exp});
      acc_cycle = cyc;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    repeat (4) @(posedge clock);
    #1;
    check("scoreboard_empty", 65'(sb.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    load_d = '0; load_e = 1'b0; load_v = 1'b0;
    addr_d = '0; addr_e = 1'b0; addr_v = 1'b0;
    data_b = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_load_b", load_b, 0);
    check("rst_addr_b", addr_b, 1);
    check("rst_data_v", data_v, 0);
    check("rst_data_e", data_e, 0);
    check("rst_data_d", data_d, 0);
    check("rst_err", err, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Addresses offered during LOAD must be held off.
    addr_d = 32'd1;
    addr_v = 1'b1;
    load_word(64'h11, 0);
    load_word(64'h22, 0);
    load_word(64'h33, 0);
    load_word(64'h44, 0);
    load_word(64'h0, 1);
    addr_v = 1'b0;
    @(negedge clock);
    check("serve_load_b", load_b, 1);
    check("serve_addr_b", addr_b, 0);
    check("serve_no_data", data_v, 0);
    @(posedge clock);
    #1;

    pop_cycles.delete();
    send_addr(32'd3, 0, 64'h44);
    first_acc = acc_cycle;
    send_addr(32'd0, 0, 64'h11);
    send_addr(32'd2, 0, 64'h33);
    idle(1);
    drain();
    check("first_latency", 65'(pop_cycles[0]), 65'(first_acc + 1));
    check("second_consec", 65'(pop_cycles[1]), 65'(first_acc + 2));
    check("third_consec", 65'(pop_cycles[2]), 65'(first_acc + 3));

    send_addr(32'd2, 0, 64'h33);
    send_addr(32'd0, 1, 64'h0);
    idle(1);
    drain();

    data_b = 1'b1;
    send_addr(32'd0, 0, 64'h11);
    send_addr(32'd1, 0, 64'h22);
    addr_d = 32'd2;
    addr_e = 1'b0;
    addr_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("hold_addr_b", addr_b, 1);
      check("hold_data_v", data_v, 1);
      check("hold_data_d", {data_e, data_d}, 65'h11);
      @(posedge clock);
      #1;
    end
    data_b = 1'b0;
    send_addr(32'd2, 0, 64'h33);
    send_addr(32'd3, 0, 64'h44);
    send_addr(32'd0, 0, 64'h11);
    send_addr(32'd1, 0, 64'h22);
    idle(1);
    drain();

    check("err_before", err, 0);
    send_addr(32'h100, 0, 64'h0);
    addr_v = 1'b0;
    @(negedge clock);
    check("err_next_cycle", err, 1);
    idle(10);
    check("err_sticky", err, 1);
    drain();

    data_b = 1'b1;
    send_addr(32'd0, 0, 64'h11);
    send_addr(32'd1, 0, 64'h22);
    idle(2);
    reset = 1'b0;
    sb.delete();
    @(posedge clock);
    #1;
    @(negedge clock);
    check("rst2_data_v", data_v, 0);
    check("rst2_load_b", load_b, 0);
    check("rst2_addr_b", addr_b, 1);
    check("rst2_err", err, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    data_b = 1'b0;
    load_word(64'hA1, 0);
    load_word(64'hB2, 0);
    load_word(64'h0, 1);
    send_addr(32'd1, 0, 64'hB2);
    send_addr(32'd0, 0, 64'hA1);
    idle(1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
